inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//   Initiator side of the instruction-memory interface: owns the PC and drives IAddr/InsMemRW into instMem.
//   instMem returns IDataOut combinationally in the same cycle as IAddr.
//   Registers each fetched word into a one-entry slot and hands it to decode over a valid/ready handshake.
//   Applies branch/jump redirects from decode, flushes the wrong-path word, and stops fetching on HALT.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded by Reset
//   HALT_OPCODE  6'b111111      IDataOut[31:26] value that stops fetching
// PORTS
//   CLK         in   1   clock; all state updates on rising edge
//   Reset       in   1   synchronous, active-high reset
//   IAddr       out  32  instruction address to instMem (= PC)
//   InsMemRW    out  1   instMem read enable; 1 only in FETCH
//   IDataOut    in   32  instruction word from instMem, valid in the same cycle as IAddr
//   PCWre       in   1   PC write enable; 0 = stall (no fetch, PC held)
//   PCSrc       in   2   redirect for the slot word being consumed: 00 seq, 01 branch, 10 jump, 11 none
//   Imm         in   32  sign-extended branch offset, in words
//   JAddr       in   26  jump target field
//   inst_out    out  32  registered instruction word
//   pc_out      out  32  address of inst_out
//   inst_valid  out  1   slot holds an instruction
//   inst_ready  in   1   decode accepts inst_out this cycle
//   halted      out  1   1 while state == HALT
// BEHAVIOUR
//   Reset (sync, any state):
//     PC <= RESET_PC; inst_out, pc_out <= 0; inst_valid <= 0; state <= RST.
//   States: RST -> FETCH (unconditional, 1 cycle, InsMemRW = 0); FETCH; HALT.
//   Definitions:
//     accept   = inst_valid & inst_ready
//     redirect = accept & PCWre & (PCSrc == 01 | PCSrc == 10)
//     fetch    = state == FETCH & PCWre & (!inst_valid | inst_ready) & !redirect
//   fetch:
//     inst_out <= IDataOut; pc_out <= PC; inst_valid <= 1; PC <= PC + 4 (mod 2^32, wraps silently).
//     Latency: word presented at IAddr in cycle N is on inst_out in cycle N+1.
//   Sequential advance happens only on fetch; PCSrc 00 or 11 never changes PC by itself.
//   redirect (priority over fetch):
//     PC <= target; inst_valid <= 0 (wrong-path word flushed); no fetch that cycle.
//     branch target = pc_out + 4 + (Imm << 2)
//     jump target   = {pc_out_plus4[31:28], JAddr, 2'b00}
//     In HALT, a redirect also returns state to FETCH (cancels a wrong-path halt).
//   accept without fetch or redirect: inst_valid <= 0.
//   Stall rules:
//     inst_valid & !inst_ready: inst_out and pc_out held stable; no fetch; PC held.
//     PCWre = 0: no fetch and no redirect; an accept still empties the slot.
//   Halt:
//     On a fetch with IDataOut[31:26] == HALT_OPCODE: the word is captured normally, then state <= HALT.
//     In HALT: InsMemRW = 0; PC frozen; no further fetches.
//     The halt word remains valid until accepted.
//     Only Reset or a redirect leaves HALT.
//   Outputs:
//     IAddr = PC in all states.
//     InsMemRW = (state == FETCH).
//     halted = (state == HALT).
// TESTING
//   1) Reset 2 cycles, inst_ready = 1, PCWre = 1, mem = 0x0,0x4,0x8 nonzero
//      -> IAddr 0,4,8 on consecutive cycles; pc_out/inst_out lag by 1 cycle.
//   2) Hold inst_ready = 0 for 3 cycles after first word
//      -> inst_out/pc_out = word@0/0 stable; IAddr stays 4; resumes at 4 with no word lost or duplicated.
//   3) Consume word at pc_out = 0x8 with PCSrc = 01, Imm = -2
//      -> wrong-path word flushed (inst_valid = 0 next cycle); next IAddr = 0x4.
//   4) Consume word at 0x10 with PCSrc = 10, JAddr = 26'h40
//      -> next IAddr = 0x100.
//   5) Word at 0xC has opcode 6'b111111
//      -> captured and valid; then halted = 1, InsMemRW = 0, IAddr frozen at 0x10.
//      -> redirect from the preceding branch in the same run returns to FETCH.
//   6) Assert Reset mid-stall with inst_valid = 1
//      -> next cycle inst_valid = 0, IAddr = RESET_PC, then fetching restarts after the RST cycle.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instMem combinationally, and hands each
// word to decode through a one-entry valid/ready slot with branch/jump redirect and HALT.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] IAddr,
    output logic        InsMemRW,
    input  logic [31:0] IDataOut,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Imm,
    input  logic [25:0] JAddr,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        halted
);

    typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;

    logic        accept, redirect, fetch;
    logic [31:0] pc_plus4, br_tgt, jmp_tgt;

    assign accept   = valid_q & inst_ready;
    assign redirect = accept & PCWre & ((PCSrc == 2'b01) | (PCSrc == 2'b10));
    assign fetch    = (state_q == ST_FETCH) & PCWre & (~valid_q | inst_ready) & ~redirect;

    // Redirect targets are relative to the word being consumed, not the fetch PC.
    assign pc_plus4 = pcout_q + 32'd4;
    assign br_tgt   = pc_plus4 + (Imm << 2);
    assign jmp_tgt  = {pc_plus4[31:28], JAddr, 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RST;
        endcase
        if (redirect) begin
            pc_d    = (PCSrc == 2'b01) ? br_tgt : jmp_tgt;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else if (fetch) begin
            inst_d  = IDataOut;
            pcout_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            if (IDataOut[31:26] == HALT_OPCODE) state_d = ST_HALT;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            pcout_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
        end
    end

    assign IAddr      = pc_q;
    assign InsMemRW   = (state_q == ST_FETCH);
    assign halted     = (state_q == ST_HALT);
    assign inst_out   = inst_q;
    assign pc_out     = pcout_q;
    assign inst_valid = valid_q;

endmodule
